// File: rtl/hash_nway_bucket.sv
// hash_nway_bucket: N-way set-associative MAC learn/lookup table with
// oldest-entry replacement, runtime flush and one-set-per-tick aging.
module hash_nway_bucket #(
    parameter int WAYS     = 4,
    parameter int ADDR_W   = 10,
    parameter int PORT_W   = 16,
    parameter int AGE_W    = 10,
    parameter int LIVE_TH  = 300,
    parameter bit REPL_OLD = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              se_req,
    input  logic              se_source,
    input  logic [47:0]       se_mac,
    input  logic [PORT_W-1:0] se_portmap,
    input  logic [ADDR_W-1:0] se_hash,
    output logic              se_ack,
    output logic              se_nak,
    output logic [PORT_W-1:0] se_result,
    output logic              se_evict,
    input  logic              aging_req,
    output logic              aging_ack,
    input  logic              flush_req,
    output logic              flush_ack,
    output logic              init_done
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int IDX_W = $clog2(WAYS);
    localparam logic [ADDR_W-1:0] LAST_SET = '1;

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_IDLE   = 4'd1;
    localparam logic [3:0] S_RD     = 4'd2;
    localparam logic [3:0] S_CMP    = 4'd3;
    localparam logic [3:0] S_ACT    = 4'd4;
    localparam logic [3:0] S_DONE   = 4'd5;
    localparam logic [3:0] S_AG_RD  = 4'd6;
    localparam logic [3:0] S_AG_CMP = 4'd7;
    localparam logic [3:0] S_AG_WR  = 4'd8;

    typedef struct packed {
        logic              v;
        logic [AGE_W-1:0]  age;
        logic [47:0]       mac;
        logic [PORT_W-1:0] pm;
    } entry_t;

    logic [3:0]        state;
    logic [ADDR_W-1:0] init_cnt;
    logic              flush_q;
    logic [ADDR_W-1:0] aging_addr;
    logic              req_src;
    logic [47:0]       req_mac;
    logic [PORT_W-1:0] req_pm;
    logic [ADDR_W-1:0] req_hash;

    entry_t            rdata [WAYS];
    entry_t            cmp_q [WAYS];
    entry_t            wdata [WAYS];
    logic              we    [WAYS];
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] rd_addr;

    logic              hit_any;
    logic [IDX_W-1:0]  hit_idx;
    logic              inv_any;
    logic [IDX_W-1:0]  inv_idx;
    logic [IDX_W-1:0]  old_idx;
    logic [AGE_W-1:0]  min_age;
    logic              wr_go;
    logic [IDX_W-1:0]  wr_idx;
    logic              evict;
    entry_t            learn_ent;

    function automatic entry_t age_ent(input entry_t e);
        age_ent = '0;
        if (e.v && e.age != '0) begin
            age_ent     = e;
            age_ent.age = e.age - 1'b1;
        end
    endfunction

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (cmp_q[k].v && cmp_q[k].mac == req_mac) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(k);
            end
            if (!cmp_q[k].v) begin
                inv_any = 1'b1;
                inv_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        old_idx = '0;
        min_age = cmp_q[0].age;
        for (int k = 1; k < WAYS; k++) begin
            if (cmp_q[k].age < min_age) begin
                min_age = cmp_q[k].age;
                old_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        wr_go  = 1'b0;
        wr_idx = '0;
        evict  = 1'b0;
        priority case (1'b1)
            hit_any: begin
                wr_go  = 1'b1;
                wr_idx = hit_idx;
            end
            inv_any: begin
                wr_go  = 1'b1;
                wr_idx = inv_idx;
            end
            default: begin
                wr_go  = REPL_OLD;
                wr_idx = old_idx;
                evict  = REPL_OLD;
            end
        endcase
    end

    always_comb begin
        learn_ent.v   = 1'b1;
        learn_ent.age = AGE_W'(LIVE_TH);
        learn_ent.mac = req_mac;
        learn_ent.pm  = req_pm;
    end

    assign rd_addr = (state == S_AG_RD) ? aging_addr : req_hash;

    always_comb begin
        waddr = req_hash;
        for (int k = 0; k < WAYS; k++) begin
            we[k]    = 1'b0;
            wdata[k] = '0;
        end
        case (state)
            S_INIT: begin
                waddr = init_cnt;
                for (int k = 0; k < WAYS; k++) we[k] = 1'b1;
            end
            S_ACT: begin
                if (req_src && wr_go) begin
                    we[wr_idx]    = 1'b1;
                    wdata[wr_idx] = learn_ent;
                end
            end
            S_AG_WR: begin
                waddr = aging_addr;
                for (int k = 0; k < WAYS; k++) begin
                    we[k]    = 1'b1;
                    wdata[k] = age_ent(cmp_q[k]);
                end
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < WAYS; k++) begin : g_way
        entry_t mem [DEPTH];
        entry_t rd_q;
        always_ff @(posedge clk) begin
            if (we[k]) mem[waddr] <= wdata[k];
            rd_q <= mem[rd_addr];
        end
        assign rdata[k] = rd_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            flush_q    <= 1'b0;
            aging_addr <= '0;
            req_src    <= 1'b0;
            req_mac    <= '0;
            req_pm     <= '0;
            req_hash   <= '0;
            se_ack     <= 1'b0;
            se_nak     <= 1'b0;
            se_evict   <= 1'b0;
            se_result  <= '0;
            aging_ack  <= 1'b0;
            flush_ack  <= 1'b0;
            init_done  <= 1'b0;
            for (int k = 0; k < WAYS; k++) cmp_q[k] <= '0;
        end else begin
            se_ack    <= 1'b0;
            se_nak    <= 1'b0;
            se_evict  <= 1'b0;
            se_result <= '0;
            aging_ack <= 1'b0;
            flush_ack <= 1'b0;
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_SET) begin
                        state     <= S_IDLE;
                        init_done <= 1'b1;
                        flush_ack <= flush_q;
                        flush_q   <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (flush_req) begin
                        state      <= S_INIT;
                        init_cnt   <= '0;
                        init_done  <= 1'b0;
                        flush_q    <= 1'b1;
                        aging_addr <= '0;
                    end else if (se_req) begin
                        state    <= S_RD;
                        req_src  <= se_source;
                        req_mac  <= se_mac;
                        req_pm   <= se_portmap;
                        req_hash <= se_hash;
                    end else if (aging_req) begin
                        state <= S_AG_RD;
                    end
                end
                S_RD: state <= S_CMP;
                S_CMP: begin
                    state <= S_ACT;
                    for (int k = 0; k < WAYS; k++) cmp_q[k] <= rdata[k];
                end
                S_ACT: begin
                    state <= S_DONE;
                    if (req_src) begin
                        se_ack   <= wr_go;
                        se_nak   <= !wr_go;
                        se_evict <= wr_go && evict;
                    end else begin
                        se_ack    <= hit_any;
                        se_nak    <= !hit_any;
                        se_result <= hit_any ? cmp_q[hit_idx].pm : '0;
                    end
                end
                S_AG_RD: state <= S_AG_CMP;
                S_AG_CMP: begin
                    state     <= S_AG_WR;
                    aging_ack <= (aging_addr == LAST_SET);
                    for (int k = 0; k < WAYS; k++) cmp_q[k] <= rdata[k];
                end
                S_AG_WR: begin
                    state      <= S_DONE;
                    aging_addr <= aging_addr + 1'b1;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_nway_bucket.sv
// tb_hash_nway_bucket: two table variants driven in lockstep and
// compared against an array-based model of the table rules.
module tb_hash_nway_bucket;
    localparam int SETS      = 8;
    localparam int WAYS      = 4;
    localparam int REQ_LAT   = 5;
    localparam int SWEEP_LAT = 5 * SETS - 1;
    localparam logic [47:0] MAC1 = 48'h0011_2233_4455;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        se_req = 1'b0;
    logic        se_source = 1'b0;
    logic [47:0] se_mac = '0;
    logic [15:0] se_portmap = '0;
    logic [2:0]  se_hash = '0;
    logic        aging_req = 1'b0;
    logic        flush_req = 1'b0;

    logic a_ack, a_nak, a_ev, a_aack, a_fack, a_idone;
    logic b_ack, b_nak, b_ev, b_aack, b_fack, b_idone;
    logic [15:0] a_res, b_res;
    logic [21:0] a_vec, b_vec;

    int n_chk = 0;
    int n_fail = 0;

    logic        mv   [2][SETS][WAYS];
    int          mage [2][SETS][WAYS];
    logic [47:0] mmac [2][SETS][WAYS];
    logic [15:0] mpm  [2][SETS][WAYS];
    int          m_ptr = 0;
    int          live [2] = '{300, 2};
    bit          repl [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    hash_nway_bucket #(
        .WAYS(WAYS), .ADDR_W(3), .PORT_W(16), .AGE_W(10),
        .LIVE_TH(300), .REPL_OLD(1'b1)
    ) dut_a (
        .clk(clk), .rstn(rstn), .se_req(se_req), .se_source(se_source),
        .se_mac(se_mac), .se_portmap(se_portmap), .se_hash(se_hash),
        .se_ack(a_ack), .se_nak(a_nak), .se_result(a_res), .se_evict(a_ev),
        .aging_req(aging_req), .aging_ack(a_aack), .flush_req(flush_req),
        .flush_ack(a_fack), .init_done(a_idone)
    );

    hash_nway_bucket #(
        .WAYS(WAYS), .ADDR_W(3), .PORT_W(16), .AGE_W(4),
        .LIVE_TH(2), .REPL_OLD(1'b0)
    ) dut_b (
        .clk(clk), .rstn(rstn), .se_req(se_req), .se_source(se_source),
        .se_mac(se_mac), .se_portmap(se_portmap), .se_hash(se_hash),
        .se_ack(b_ack), .se_nak(b_nak), .se_result(b_res), .se_evict(b_ev),
        .aging_req(aging_req), .aging_ack(b_aack), .flush_req(flush_req),
        .flush_ack(b_fack), .init_done(b_idone)
    );

    assign a_vec = {a_ack, a_nak, a_ev, a_aack, a_fack, a_idone, a_res};
    assign b_vec = {b_ack, b_nak, b_ev, b_aack, b_fack, b_idone, b_res};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    mv[d][s][w]   = 1'b0;
                    mage[d][s][w] = 0;
                    mmac[d][s][w] = '0;
                    mpm[d][s][w]  = '0;
                end
        m_ptr = 0;
    endtask

    task automatic m_tick();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < WAYS; w++) begin
                if (mv[d][m_ptr][w] && mage[d][m_ptr][w] > 0) begin
                    mage[d][m_ptr][w]--;
                end else begin
                    mv[d][m_ptr][w]   = 1'b0;
                    mage[d][m_ptr][w] = 0;
                    mmac[d][m_ptr][w] = '0;
                    mpm[d][m_ptr][w]  = '0;
                end
            end
        m_ptr = (m_ptr + 1) % SETS;
    endtask

    task automatic m_op(input int d, input logic src, input logic [47:0] mac,
                        input logic [15:0] pm, input int h,
                        output logic ack, output logic nak,
                        output logic ev, output logic [15:0] res);
        int w;
        w = -1;
        ack = 1'b0; nak = 1'b0; ev = 1'b0; res = '0;
        for (int k = 0; k < WAYS; k++)
            if (w < 0 && mv[d][h][k] && mmac[d][h][k] == mac) w = k;
        if (!src) begin
            if (w >= 0) begin
                ack = 1'b1;
                res = mpm[d][h][w];
            end else begin
                nak = 1'b1;
            end
        end else begin
            for (int k = 0; k < WAYS; k++)
                if (w < 0 && !mv[d][h][k]) w = k;
            if (w < 0 && repl[d]) begin
                w = 0;
                for (int k = 1; k < WAYS; k++)
                    if (mage[d][h][k] < mage[d][h][w]) w = k;
                ev = 1'b1;
            end
            if (w < 0) begin
                nak = 1'b1;
            end else begin
                mv[d][h][w]   = 1'b1;
                mage[d][h][w] = live[d];
                mmac[d][h][w] = mac;
                mpm[d][h][w]  = pm;
                ack = 1'b1;
            end
        end
    endtask

    task automatic req(input string tag, input logic src, input logic [47:0] mac,
                       input logic [15:0] pm, input int h);
        logic xa_ack, xa_nak, xa_ev, xb_ack, xb_nak, xb_ev;
        logic [15:0] xa_res, xb_res;
        int n;
        m_op(0, src, mac, pm, h, xa_ack, xa_nak, xa_ev, xa_res);
        m_op(1, src, mac, pm, h, xb_ack, xb_nak, xb_ev, xb_res);
        repeat (2) @(posedge clk);
        #1;
        se_req = 1'b1; se_source = src; se_mac = mac;
        se_portmap = pm; se_hash = 3'(h);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(a_ack | a_nak | b_ack | b_nak) && n < 12);
        se_req = 1'b0;
        chk({tag, ".lat"}, 64'(n), 64'(REQ_LAT));
        chk({tag, ".a"}, {a_ack, a_nak, a_ev, a_res}, {xa_ack, xa_nak, xa_ev, xa_res});
        chk({tag, ".b"}, {b_ack, b_nak, b_ev, b_res}, {xb_ack, xb_nak, xb_ev, xb_res});
    endtask

    task automatic sweep(input string tag);
        int n;
        for (int s = 0; s < SETS; s++) m_tick();
        repeat (2) @(posedge clk);
        #1 aging_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(a_aack | b_aack) && n < 8 * SETS);
        aging_req = 1'b0;
        chk({tag, ".lat"}, 64'(n), 64'(SWEEP_LAT));
        chk({tag, ".ack"}, {a_aack, b_aack}, 2'b11);
    endtask

    task automatic tick();
        m_tick();
        repeat (2) @(posedge clk);
        #1 aging_req = 1'b1;
        @(posedge clk);
        #1 aging_req = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic wait_init(input string tag, input logic fack);
        int n;
        n = 0;
        while (!a_idone && n < 4 * SETS) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".done"}, {a_idone, b_idone}, 2'b11);
        chk({tag, ".fack"}, {a_fack, b_fack}, {fack, fack});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int idx;
        logic src;
        m_clear();
        #12;
        chk("rst.a", a_vec, 22'h0);
        chk("rst.b", b_vec, 22'h0);
        @(negedge clk);
        rstn = 1'b1;
        wait_init("init", 1'b0);

        req("t1.learn", 1'b1, MAC1, 16'h0004, 5);
        req("t1.look", 1'b0, MAC1, 16'h0, 5);

        req("t2.miss", 1'b0, 48'hDEAD_BEEF_0001, 16'h0, 5);
        req("t2.relearn", 1'b1, MAC1, 16'h0008, 5);
        req("t2.look", 1'b0, MAC1, 16'h0, 5);

        for (int i = 0; i < WAYS; i++)
            req("t3.fill", 1'b1, 48'hA000_0000_0000 + 48'(i), 16'(i + 1), 7);
        repeat (3) sweep("t3.sweep");
        req("t3.ref0", 1'b1, 48'hA000_0000_0000, 16'h0011, 7);
        req("t3.ref1", 1'b1, 48'hA000_0000_0001, 16'h0012, 7);
        req("t3.ref3", 1'b1, 48'hA000_0000_0003, 16'h0013, 7);
        req("t3.new", 1'b1, 48'hA000_0000_0010, 16'h00F0, 7);
        for (int i = 0; i < WAYS; i++)
            req("t3.look", 1'b0, 48'hA000_0000_0000 + 48'(i), 16'h0, 7);
        req("t3.looknew", 1'b0, 48'hA000_0000_0010, 16'h0, 7);
        for (int i = 0; i < WAYS; i++)
            req("t3.fill6", 1'b1, 48'hB000_0000_0000 + 48'(i), 16'(i + 8), 6);
        req("t3.full", 1'b1, 48'hB000_0000_0010, 16'h0F00, 6);
        for (int i = 0; i < WAYS; i++)
            req("t3.look6", 1'b0, 48'hB000_0000_0000 + 48'(i), 16'h0, 6);
        req("t3.look6new", 1'b0, 48'hB000_0000_0010, 16'h0, 6);

        req("t4.learn", 1'b1, 48'hCAFE_0000_0001, 16'h0020, 1);
        sweep("t4.sw1");
        req("t4.look1", 1'b0, 48'hCAFE_0000_0001, 16'h0, 1);
        sweep("t4.sw2");
        req("t4.look2", 1'b0, 48'hCAFE_0000_0001, 16'h0, 1);
        sweep("t4.sw3");
        req("t4.look3", 1'b0, 48'hCAFE_0000_0001, 16'h0, 1);

        for (int i = 0; i < 60; i++) begin
            idx = int'($urandom_range(0, 23));
            src = 1'($urandom_range(0, 1));
            req("rnd", src, 48'hC0DE_0000_0000 + 48'(idx), 16'($urandom), idx % 4);
            if (i % 20 == 19) sweep("rnd.sweep");
        end

        repeat (3) tick();
        repeat (2) @(posedge clk);
        #1;
        flush_req = 1'b1; se_req = 1'b1; se_source = 1'b0;
        se_mac = 48'hA000_0000_0000; se_hash = 3'd7;
        @(posedge clk);
        #1 flush_req = 1'b0;
        n = 0;
        while (!a_idone && n < 4 * SETS) begin
            @(negedge clk);
            if (!a_idone) n++;
        end
        chk("t5.initlow", 64'(n), 64'(SETS));
        chk("t5.fack", {a_fack, b_fack, b_idone}, 3'b111);
        m_clear();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(a_ack | a_nak | b_ack | b_nak) && n < 12);
        se_req = 1'b0;
        chk("t5.pend.lat", 64'(n), 64'(REQ_LAT - 1));
        chk("t5.pend", {a_ack, a_nak, a_res, b_ack, b_nak, b_res},
            {1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'h0});
        req("t5.look1", 1'b0, 48'hC0DE_0000_0001, 16'h0, 1);
        req("t5.look2", 1'b0, 48'hB000_0000_0001, 16'h0, 6);
        req("t5.learn", 1'b1, 48'hE000_0000_0001, 16'h0040, 2);
        sweep("t5.sweep");
        req("t5.lookage", 1'b0, 48'hE000_0000_0001, 16'h0, 2);

        repeat (2) @(posedge clk);
        #1;
        se_req = 1'b1; se_source = 1'b1; se_mac = MAC1;
        se_portmap = 16'h0080; se_hash = 3'd5;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        se_req = 1'b0;
        #1;
        chk("t6.rst.a", a_vec, 22'h0);
        chk("t6.rst.b", b_vec, 22'h0);
        m_clear();
        @(negedge clk);
        rstn = 1'b1;
        wait_init("t6.init", 1'b0);
        req("t6.look", 1'b0, MAC1, 16'h0, 5);
        sweep("t6.sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
